alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the cpu6502 datapath. It has:
- a WIDTH-bit result hold register;
- a full flag set (carry, overflow, half carry, zero, negative);
- carry-in shift and rotate operations;
- optional two-cycle BCD add and subtract, with a start/busy/done handshake.

It is the next-generation replacement for the 8-bit combinational-plus-hold-register ALU. Binary operations complete in one cycle. Decimal operations take one extra adjust cycle.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 when DECIMAL_EN=1
- DECIMAL_EN, 1, 1 = decimal mode supported; 0 = i_decimal ignored

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset_n  in  1  reset; synchronous, active-low
- i_start  in  1  launch operation; sampled only in IDLE
- i_op  in  3  0 SUM, 1 AND, 2 EOR, 3 OR, 4 SR, 5 SL, 6 PASSB, 7 reserved
- i_a  in  WIDTH  A operand
- i_b  in  WIDTH  B operand
- i_b_invert  in  1  B' = ~i_b when 1; in decimal SUM, selects subtract
- i_carry  in  1  carry-in; for decimal subtract, 1 = no borrow
- i_decimal  in  1  request BCD arithmetic; affects SUM only
- o_busy  out  1  high during ADJUST
- o_done  out  1  one-cycle pulse when o_add and flags are updated
- o_add  out  WIDTH  result hold register
- o_carry, o_overflow, o_half_carry, o_zero, o_negative  out  1 each  flag registers

## Operation
- States: IDLE, ADJUST.
- Operand B' = i_b_invert ? ~i_b : i_b. All ops except decimal SUM use B'.
- SUM (binary): {carry, r} = i_a + B' + i_carry.
  - overflow = (a[W-1]==B'[W-1]) && (r[W-1]!=a[W-1]).
  - half_carry = carry out of bit 3.
- AND/EOR/OR: r = a op B'. carry, overflow and half_carry are 0.
- SR: r = {i_carry, B'[W-1:1]}, carry = B'[0]. LSR uses i_carry=0; ROR uses i_carry=C.
- SL: r = {B'[W-2:0], i_carry}, carry = B'[W-1].
- SR/SL: overflow and half_carry are 0.
- PASSB: r = B'. Other flags are 0.
- Op 7: r = 0; zero = 1.
- All ops: zero = (r==0), negative = r[W-1], computed on the final result.
- Decimal SUM applies when i_decimal && DECIMAL_EN && op==SUM.
  - Start cycle: the binary result of a + B' + c is computed. Only overflow and half_carry are kept from it, with the binary rules above.
  - Operands and mode are latched internally. i_a/i_b may change afterwards.
- ADJUST, add (i_b_invert=0): per 4-bit digit i from LSB, c0 = i_carry.
  - t = a_i + b_i + c.
  - If t>9: digit = (t+6)[3:0], c = 1. Otherwise digit = t, c = 0.
  - Final c goes to o_carry.
- ADJUST, subtract (i_b_invert=1): uses un-inverted i_b; borrow0 = !i_carry.
  - t = a_i - b_i - borrow.
  - If t<0: digit = (t+10)[3:0], borrow = 1. Otherwise digit = t, borrow = 0.
  - o_carry = !final borrow.
- Non-BCD digits follow these rules exactly. The result is deterministic.

## Timing
- Reset (i_reset_n=0 at an edge): state→IDLE. o_add, every flag, o_busy and o_done become 0. Reset overrides start.
- Binary op: i_start in IDLE at edge N → o_add/flags valid and o_done=1 after edge N. o_done drops after edge N+1 unless a new start occurs. Back-to-back starts every cycle are allowed.
- Decimal op: start at edge N → state ADJUST, o_busy=1, o_done=0, o_add/flags unchanged. Edge N+1 → o_add/flags updated, o_done=1, o_busy=0, IDLE.
- i_start while busy: ignored, not queued.
- Reset during ADJUST: aborts with no o_done, and outputs are cleared.
- Outputs hold their values between operations.
- DECIMAL_EN=0: every op is one-cycle; o_busy is constant 0.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Binary SUM a=0x50, b=0x50, c=0 → o_add=0xA0, overflow=1, carry=0, negative=1, half_carry=0, o_done exactly one cycle after start. Back-to-back AND 0xF0&0x3C the next cycle → 0x30.
- Binary subtract a=0x10, b=0x20, invert=1, c=1 → 0xF0, carry=0, negative=1, overflow=0.
- Decimal add a=0x58, b=0x46, c=1:
  - o_busy=1 for one cycle, o_done on the second edge, o_add=0x05, carry=1.
  - A start during busy (a=0x01, b=0x01) is ignored.
- Decimal subtract a=0x12, b=0x21, invert=1, c=1 → 0x91, carry=0. At WIDTH=16: 0x9999+0x0001, c=0 → 0x0000, carry=1, zero=1.
- SR b=0x81, c=1 → 0xC0, carry=1. SL b=0x81, c=0 → 0x02, carry=1. Op 7 → 0x00, zero=1.
- Reset low during ADJUST → next cycle all outputs 0, no o_done, IDLE. A following binary start completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request and result/flag bundle for alu_seq.
//   master: drives i_start/i_op/i_a/i_b/i_b_invert/i_carry/i_decimal,
//           receives o_busy/o_done/o_add and the flag outputs.
//   slave : the ALU side of the same bundle.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_b_invert;
    logic             i_carry;
    logic             i_decimal;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_add;
    logic             o_carry;
    logic             o_overflow;
    logic             o_half_carry;
    logic             o_zero;
    logic             o_negative;

    modport master (
        output i_start, i_op, i_a, i_b, i_b_invert, i_carry, i_decimal,
        input  o_busy, o_done, o_add, o_carry, o_overflow, o_half_carry,
               o_zero, o_negative
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_b_invert, i_carry, i_decimal,
        output o_busy, o_done, o_add, o_carry, o_overflow, o_half_carry,
               o_zero, o_negative
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with full flag set and optional two-cycle BCD
// add/subtract.
//   i_clk     : clock, all state changes on the rising edge
//   i_reset_n : synchronous active-low reset
//   bus       : alu_seq_if.slave - start/op/operands in; busy/done,
//               result hold register and flag registers out
// Binary ops finish one edge after start; decimal SUM goes through one
// ADJUST cycle before the result and flags are written.
module alu_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          DECIMAL_EN = 1'b1
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    alu_seq_if.slave bus
);
    localparam int unsigned NDIG = WIDTH / 4;

    typedef enum logic [2:0] {
        OP_SUM   = 3'd0,
        OP_AND   = 3'd1,
        OP_EOR   = 3'd2,
        OP_OR    = 3'd3,
        OP_SR    = 3'd4,
        OP_SL    = 3'd5,
        OP_PASSB = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ADJUST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] add_q, add_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             hc_q, hc_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operands and mode captured at a decimal start
    logic [WIDTH-1:0] da_q, da_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic             dsub_q, dsub_d;
    logic             dcin_q, dcin_d;
    logic             dovf_q, dovf_d;
    logic             dhc_q, dhc_d;

    // Binary datapath
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   a_ext, b_ext, sum_full;
    logic [WIDTH-1:0] bin_r;
    logic             bin_c, bin_v, bin_h;
    logic             sum_v, sum_h;
    logic             dec_go;

    always_comb begin
        bp       = bus.i_b_invert ? ~bus.i_b : bus.i_b;
        a_ext    = {1'b0, bus.i_a};
        b_ext    = {1'b0, bp};
        sum_full = a_ext + b_ext + (WIDTH+1)'(bus.i_carry);
        sum_v    = (bus.i_a[WIDTH-1] == bp[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != bus.i_a[WIDTH-1]);
        // carry into bit 4 recovered from the sum and operand bits
        sum_h    = sum_full[4] ^ a_ext[4] ^ b_ext[4];
        dec_go   = DECIMAL_EN && bus.i_decimal && (op_e'(bus.i_op) == OP_SUM);
        bin_r    = '0;
        bin_c    = 1'b0;
        bin_v    = 1'b0;
        bin_h    = 1'b0;
        case (op_e'(bus.i_op))
            OP_SUM: begin
                bin_r = sum_full[WIDTH-1:0];
                bin_c = sum_full[WIDTH];
                bin_v = sum_v;
                bin_h = sum_h;
            end
            OP_AND:   bin_r = bus.i_a & bp;
            OP_EOR:   bin_r = bus.i_a ^ bp;
            OP_OR:    bin_r = bus.i_a | bp;
            OP_SR: begin
                bin_r = {bus.i_carry, bp[WIDTH-1:1]};
                bin_c = bp[0];
            end
            OP_SL: begin
                bin_r = {bp[WIDTH-2:0], bus.i_carry};
                bin_c = bp[WIDTH-1];
            end
            OP_PASSB: bin_r = bp;
            default:  bin_r = '0;
        endcase
    end

    // Digit-serial BCD adjust on latched operands; c is carry or borrow
    logic [WIDTH-1:0] bcd_r;
    logic             bcd_c, bcd_cout;
    logic [3:0]       dg_a, dg_b, dg_r;
    logic [4:0]       t_add;
    logic [5:0]       t_sub;

    always_comb begin
        bcd_r = '0;
        bcd_c = dsub_q ? ~dcin_q : dcin_q;
        dg_a  = '0;
        dg_b  = '0;
        dg_r  = '0;
        t_add = '0;
        t_sub = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            dg_a = da_q[4*i +: 4];
            dg_b = db_q[4*i +: 4];
            if (!dsub_q) begin
                t_add = {1'b0, dg_a} + {1'b0, dg_b} + 5'(bcd_c);
                if (t_add > 5'd9) begin
                    dg_r  = 4'(t_add + 5'd6);
                    bcd_c = 1'b1;
                end else begin
                    dg_r  = t_add[3:0];
                    bcd_c = 1'b0;
                end
            end else begin
                t_sub = {2'b00, dg_a} - {2'b00, dg_b} - 6'(bcd_c);
                if ($signed(t_sub) < 0) begin
                    dg_r  = 4'(t_sub + 6'd10);
                    bcd_c = 1'b1;
                end else begin
                    dg_r  = 4'(t_sub);
                    bcd_c = 1'b0;
                end
            end
            bcd_r[4*i +: 4] = dg_r;
        end
        bcd_cout = dsub_q ? ~bcd_c : bcd_c;
    end

    // Next-state and output register update
    always_comb begin
        state_d = state_q;
        add_d   = add_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        hc_d    = hc_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        da_d    = da_q;
        db_d    = db_q;
        dsub_d  = dsub_q;
        dcin_d  = dcin_q;
        dovf_d  = dovf_q;
        dhc_d   = dhc_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (dec_go) begin
                        state_d = ADJUST;
                        busy_d  = 1'b1;
                        da_d    = bus.i_a;
                        db_d    = bus.i_b;
                        dsub_d  = bus.i_b_invert;
                        dcin_d  = bus.i_carry;
                        dovf_d  = sum_v;
                        dhc_d   = sum_h;
                    end else begin
                        add_d   = bin_r;
                        carry_d = bin_c;
                        ovf_d   = bin_v;
                        hc_d    = bin_h;
                        zero_d  = (bin_r == '0);
                        neg_d   = bin_r[WIDTH-1];
                        done_d  = 1'b1;
                    end
                end
            end
            ADJUST: begin
                state_d = IDLE;
                add_d   = bcd_r;
                carry_d = bcd_cout;
                ovf_d   = dovf_q;
                hc_d    = dhc_q;
                zero_d  = (bcd_r == '0);
                neg_d   = bcd_r[WIDTH-1];
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            add_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            hc_q    <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
            dsub_q  <= 1'b0;
            dcin_q  <= 1'b0;
            dovf_q  <= 1'b0;
            dhc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            hc_q    <= hc_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            da_q    <= da_d;
            db_q    <= db_d;
            dsub_q  <= dsub_d;
            dcin_q  <= dcin_d;
            dovf_q  <= dovf_d;
            dhc_q   <= dhc_d;
        end
    end

    assign bus.o_add        = add_q;
    assign bus.o_carry      = carry_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_half_carry = hc_q;
    assign bus.o_zero       = zero_q;
    assign bus.o_negative   = neg_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
    logic i_clk = 1'b0;
    logic i_reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) u_dut8 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus8.slave)
    );

    alu_seq #(.WIDTH(16), .DECIMAL_EN(1'b1)) u_dut16 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus16.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle away from it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic go8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic inv, input logic c, input logic dec);
        bus8.i_start    = 1'b1;
        bus8.i_op       = op;
        bus8.i_a        = a;
        bus8.i_b        = b;
        bus8.i_b_invert = inv;
        bus8.i_carry    = c;
        bus8.i_decimal  = dec;
    endtask

    initial begin
        i_reset_n = 1'b0;
        go8(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        bus8.i_start     = 1'b0;
        bus16.i_start    = 1'b0;
        bus16.i_op       = 3'd0;
        bus16.i_a        = '0;
        bus16.i_b        = '0;
        bus16.i_b_invert = 1'b0;
        bus16.i_carry    = 1'b0;
        bus16.i_decimal  = 1'b0;
        tick();
        tick();
        chk("rst_add",  32'(bus8.o_add), 32'h0);
        chk("rst_flags", 32'({bus8.o_carry, bus8.o_overflow, bus8.o_half_carry,
                              bus8.o_zero, bus8.o_negative}), 32'h0);
        chk("rst_busy_done", 32'({bus8.o_busy, bus8.o_done}), 32'h0);
        #3 i_reset_n = 1'b1;

        // Binary SUM with signed overflow, then back-to-back AND
        go8(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sum_add",  32'(bus8.o_add), 32'hA0);
        chk("sum_cvhn", 32'({bus8.o_carry, bus8.o_overflow, bus8.o_half_carry,
                             bus8.o_negative}), 32'b0101);
        chk("sum_done", 32'(bus8.o_done), 32'h1);
        go8(3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        chk("and_add",  32'(bus8.o_add), 32'h30);
        chk("and_done", 32'(bus8.o_done), 32'h1);
        bus8.i_start = 1'b0;
        tick();
        chk("idle_done", 32'(bus8.o_done), 32'h0);
        chk("idle_hold", 32'(bus8.o_add), 32'h30);

        // Binary subtract 0x10 - 0x20
        go8(3'd0, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        tick();
        bus8.i_start = 1'b0;
        chk("sub_add",  32'(bus8.o_add), 32'hF0);
        chk("sub_cvhn", 32'({bus8.o_carry, bus8.o_overflow, bus8.o_half_carry,
                             bus8.o_negative}), 32'b0011);

        // Decimal add 58 + 46 + 1 = 105
        go8(3'd0, 8'h58, 8'h46, 1'b0, 1'b1, 1'b1);
        tick();
        chk("dadd_busy", 32'({bus8.o_busy, bus8.o_done}), 32'b10);
        chk("dadd_hold", 32'(bus8.o_add), 32'hF0);
        go8(3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        bus8.i_start = 1'b0;
        chk("dadd_add",  32'(bus8.o_add), 32'h05);
        chk("dadd_cv",   32'({bus8.o_carry, bus8.o_overflow}), 32'b11);
        chk("dadd_done", 32'({bus8.o_busy, bus8.o_done}), 32'b01);
        tick();
        chk("ign_done", 32'(bus8.o_done), 32'h0);
        chk("ign_add",  32'(bus8.o_add), 32'h05);

        // Decimal subtract 12 - 21 = 91 with borrow
        go8(3'd0, 8'h12, 8'h21, 1'b1, 1'b1, 1'b1);
        tick();
        bus8.i_start = 1'b0;
        tick();
        chk("dsub_add",  32'(bus8.o_add), 32'h91);
        chk("dsub_cvhn", 32'({bus8.o_carry, bus8.o_overflow, bus8.o_half_carry,
                              bus8.o_negative}), 32'b0011);

        // Shifts and reserved op
        go8(3'd4, 8'h00, 8'h81, 1'b0, 1'b1, 1'b0);
        tick();
        chk("sr_add", 32'(bus8.o_add), 32'hC0);
        chk("sr_cn",  32'({bus8.o_carry, bus8.o_negative}), 32'b11);
        go8(3'd5, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sl_add", 32'(bus8.o_add), 32'h02);
        chk("sl_cz",  32'({bus8.o_carry, bus8.o_zero}), 32'b10);
        go8(3'd7, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0);
        tick();
        bus8.i_start = 1'b0;
        chk("op7_add", 32'(bus8.o_add), 32'h00);
        chk("op7_zc",  32'({bus8.o_zero, bus8.o_carry}), 32'b10);

        // Reset while in ADJUST, then a normal binary op
        go8(3'd0, 8'h45, 8'h45, 1'b0, 1'b0, 1'b1);
        tick();
        bus8.i_start = 1'b0;
        chk("radj_busy", 32'(bus8.o_busy), 32'h1);
        i_reset_n = 1'b0;
        tick();
        chk("radj_add",   32'(bus8.o_add), 32'h0);
        chk("radj_flags", 32'({bus8.o_busy, bus8.o_done, bus8.o_carry,
                               bus8.o_zero, bus8.o_negative}), 32'h0);
        i_reset_n = 1'b1;
        tick();
        chk("radj_nodone", 32'(bus8.o_done), 32'h0);
        go8(3'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        bus8.i_start = 1'b0;
        chk("post_add",  32'(bus8.o_add), 32'h03);
        chk("post_done", 32'(bus8.o_done), 32'h1);

        // 16-bit decimal add 9999 + 0001 = 0000 carry out
        bus16.i_start   = 1'b1;
        bus16.i_a       = 16'h9999;
        bus16.i_b       = 16'h0001;
        bus16.i_carry   = 1'b0;
        bus16.i_decimal = 1'b1;
        tick();
        bus16.i_start = 1'b0;
        chk("d16_busy", 32'(bus16.o_busy), 32'h1);
        tick();
        chk("d16_add",  32'(bus16.o_add), 32'h0000);
        chk("d16_cz",   32'({bus16.o_carry, bus16.o_zero, bus16.o_done}), 32'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
